// File: rtl/window_match_tracker.sv
// Windowed |A-B| comparator with hit/miss hysteresis lock FSM (2-edge latency to match).
// Optional macro PROX_SENTINEL_EN: samples carrying SENT_A on A or SENT_B on B are ignored.
module window_match_tracker #(
   parameter int W          = 10,
   parameter int HIT_COUNT  = 4,
   parameter int MISS_COUNT = 4,
   parameter int SENT_A     = 100,
   parameter int SENT_B     = 0
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         CLR,
   input  logic         in_valid,
   input  logic [W-1:0] Data_in_A,
   input  logic [W-1:0] Data_in_B,
   input  logic [W-1:0] TOL,
   output logic [W:0]   abs_diff,
   output logic         diff_valid,
   output logic         in_window,
   output logic         match,
   output logic         lock_rise,
   output logic         lock_fall,
   output logic [1:0]   dbg_state
);

   localparam int MAXC = (HIT_COUNT > MISS_COUNT) ? HIT_COUNT : MISS_COUNT;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] HIT_LAST  = CW'(HIT_COUNT - 1);
   localparam logic [CW-1:0] MISS_LAST = CW'(MISS_COUNT - 1);

   typedef enum logic [1:0] {
      UNLOCKED  = 2'd0,
      ACQUIRING = 2'd1,
      LOCKED    = 2'd2,
      RELEASING = 2'd3
   } state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [W:0]    abs_diff_q;
   logic          diff_valid_q;
   logic          in_window_q;
   logic          match_q;
   logic          lock_rise_q;
   logic          lock_fall_q;

   logic          sample_ok;
   logic [W:0]    diff_d;
   logic          win_d;

`ifdef PROX_SENTINEL_EN
   localparam logic [W-1:0] SENT_A_V = W'(SENT_A);
   localparam logic [W-1:0] SENT_B_V = W'(SENT_B);
`else
   logic unused_sent;
   assign unused_sent = ^{W'(SENT_A), W'(SENT_B)};
`endif

   // Difference is formed in W+1 bits so the full-scale case never wraps.
   always_comb begin
      sample_ok = in_valid;
`ifdef PROX_SENTINEL_EN
      if ((Data_in_A == SENT_A_V) || (Data_in_B == SENT_B_V)) sample_ok = 1'b0;
`endif
      if (Data_in_A >= Data_in_B) diff_d = {1'b0, Data_in_A} - {1'b0, Data_in_B};
      else                        diff_d = {1'b0, Data_in_B} - {1'b0, Data_in_A};
      win_d = (diff_d < {1'b0, TOL});
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= UNLOCKED;
         cnt_q        <= '0;
         abs_diff_q   <= '0;
         diff_valid_q <= 1'b0;
         in_window_q  <= 1'b0;
         match_q      <= 1'b0;
         lock_rise_q  <= 1'b0;
         lock_fall_q  <= 1'b0;
      end else if (CLR) begin
         state_q      <= UNLOCKED;
         cnt_q        <= '0;
         abs_diff_q   <= '0;
         diff_valid_q <= 1'b0;
         in_window_q  <= 1'b0;
         match_q      <= 1'b0;
         lock_rise_q  <= 1'b0;
         lock_fall_q  <= 1'b0;
      end else begin
         lock_rise_q  <= 1'b0;
         lock_fall_q  <= 1'b0;
         diff_valid_q <= sample_ok;
         if (sample_ok) begin
            abs_diff_q  <= diff_d;
            in_window_q <= win_d;
         end
         // Stage 2 only advances on a delayed-valid sample; gaps freeze cnt.
         if (diff_valid_q) begin
            case (state_q)
               UNLOCKED: begin
                  if (in_window_q) begin
                     if (HIT_COUNT == 1) begin
                        state_q     <= LOCKED;
                        match_q     <= 1'b1;
                        lock_rise_q <= 1'b1;
                        cnt_q       <= '0;
                     end else begin
                        state_q <= ACQUIRING;
                        cnt_q   <= CW'(1);
                     end
                  end
               end
               ACQUIRING: begin
                  if (!in_window_q) begin
                     state_q <= UNLOCKED;
                     cnt_q   <= '0;
                  end else if (cnt_q == HIT_LAST) begin
                     state_q     <= LOCKED;
                     match_q     <= 1'b1;
                     lock_rise_q <= 1'b1;
                     cnt_q       <= '0;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
               LOCKED: begin
                  if (in_window_q) begin
                     cnt_q <= '0;
                  end else if (MISS_COUNT == 1) begin
                     state_q     <= UNLOCKED;
                     match_q     <= 1'b0;
                     lock_fall_q <= 1'b1;
                     cnt_q       <= '0;
                  end else begin
                     state_q <= RELEASING;
                     cnt_q   <= CW'(1);
                  end
               end
               RELEASING: begin
                  if (in_window_q) begin
                     state_q <= LOCKED;
                     cnt_q   <= '0;
                  end else if (cnt_q == MISS_LAST) begin
                     state_q     <= UNLOCKED;
                     match_q     <= 1'b0;
                     lock_fall_q <= 1'b1;
                     cnt_q       <= '0;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
               default: begin
                  state_q <= UNLOCKED;
                  match_q <= 1'b0;
                  cnt_q   <= '0;
               end
            endcase
         end
      end
   end

   assign abs_diff   = abs_diff_q;
   assign diff_valid = diff_valid_q;
   assign in_window  = in_window_q;
   assign match      = match_q;
   assign lock_rise  = lock_rise_q;
   assign lock_fall  = lock_fall_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_window_match_tracker.sv
// Bench for window_match_tracker: table of single samples plus hand-built lock/release sequences.
// Inputs change and outputs are sampled 1 ns after each rising CLK edge.
module tb_window_match_tracker;

   localparam int W = 10;
`ifdef PROX_SENTINEL_EN
   localparam bit SENT = 1'b1;
`else
   localparam bit SENT = 1'b0;
`endif

   logic         CLK = 1'b0;
   logic         RST;
   logic         CLR;
   logic         in_valid;
   logic [W-1:0] Data_in_A;
   logic [W-1:0] Data_in_B;
   logic [W-1:0] TOL;
   logic [W:0]   abs_diff;
   logic         diff_valid;
   logic         in_window;
   logic         match;
   logic         lock_rise;
   logic         lock_fall;
   logic [1:0]   dbg_state;

   window_match_tracker dut (
      .CLK        (CLK),
      .RST        (RST),
      .CLR        (CLR),
      .in_valid   (in_valid),
      .Data_in_A  (Data_in_A),
      .Data_in_B  (Data_in_B),
      .TOL        (TOL),
      .abs_diff   (abs_diff),
      .diff_valid (diff_valid),
      .in_window  (in_window),
      .match      (match),
      .lock_rise  (lock_rise),
      .lock_fall  (lock_fall),
      .dbg_state  (dbg_state)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic         v;
      int           a;
      int           b;
      int           tol;
      logic [W:0]   d;
      logic         w;
   } vec_t;

   vec_t           vecs[$];
   logic [W+1:0]   exp_q[$];
   int             tests = 0;
   int             fails = 0;

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic add_vec(input int v, input int a, input int b, input int tol, input int d, input int w);
      vec_t x;
      x.v = v[0]; x.a = a; x.b = b; x.tol = tol; x.d = (W+1)'(d); x.w = w[0];
      vecs.push_back(x);
   endtask

   function automatic logic [W+1:0] model(input int a, input int b, input int tol);
      int d;
      d = (a > b) ? a - b : b - a;
      return {(d < tol) ? 1'b1 : 1'b0, (W+1)'(d)};
   endfunction

   // Drive one cycle, then check stage-1 via the scoreboard and the lock outputs.
   task automatic cycle(input logic v, input logic c, input int a, input int b, input int tol,
                        input logic [W+1:0] e, input logic m, input logic r, input logic f);
      logic         eff;
      logic [W+1:0] got;
      in_valid  = v;
      CLR       = c;
      Data_in_A = W'(a);
      Data_in_B = W'(b);
      TOL       = W'(tol);
      eff = v && !c;
`ifdef PROX_SENTINEL_EN
      if (a == 100 || b == 0) eff = 1'b0;
`endif
      if (eff) exp_q.push_back(e);
      @(posedge CLK);
      #1;
      check("diff_valid", diff_valid, eff);
      if (diff_valid) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_underflow: got diff_valid=1 expected no pending sample");
         end else begin
            got = exp_q.pop_front();
            check("abs_diff", abs_diff, got[W:0]);
            check("in_window", in_window, got[W+1]);
         end
      end
      if (c) begin
         check("clr_abs_diff", abs_diff, 0);
         check("clr_in_window", in_window, 0);
      end
      check("match", match, m);
      check("lock_rise", lock_rise, r);
      check("lock_fall", lock_fall, f);
   endtask

   task automatic hit(input logic m, input logic r, input logic f);
      cycle(1'b1, 1'b0, 300, 150, 200, model(300, 150, 200), m, r, f);
   endtask

   task automatic miss(input logic m, input logic r, input logic f);
      cycle(1'b1, 1'b0, 350, 150, 200, model(350, 150, 200), m, r, f);
   endtask

   task automatic idle(input logic m, input logic r, input logic f);
      cycle(1'b0, 1'b0, 0, 0, 0, '0, m, r, f);
   endtask

   initial begin
      RST = 1'b1; CLR = 1'b0; in_valid = 1'b0;
      Data_in_A = '0; Data_in_B = '0; TOL = '0;
      repeat (2) @(posedge CLK);
      #1;
      check("rst_abs_diff", abs_diff, 0);
      check("rst_diff_valid", diff_valid, 0);
      check("rst_in_window", in_window, 0);
      check("rst_match", match, 0);
      check("rst_lock_rise", lock_rise, 0);
      check("rst_lock_fall", lock_fall, 0);
      check("rst_state", dbg_state, 0);
      @(negedge CLK);
      RST = 1'b0;

      // Single-sample window checks; never 4 hits in a row, so match stays 0.
      add_vec(1, 300,  150, 200, 150,  1);
      add_vec(1, 350,  150, 200, 200,  0);
      add_vec(1, 349,  150, 200, 199,  1);
      add_vec(1,   0, 1023, 200, 1023, 0);
      add_vec(1, 1023,   0, 1023, 1023, 0);
      add_vec(1,   5,    5,   0,   0,  0);
      add_vec(1,   5,    5,   1,   0,  1);
      for (int i = 0; i < vecs.size(); i++)
         cycle(vecs[i].v, 1'b0, vecs[i].a, vecs[i].b, vecs[i].tol,
               {vecs[i].w, vecs[i].d}, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 0, 0, 0, '0, 1'b0, 1'b0, 1'b0);
      check("table_clr_state", dbg_state, 0);

      // Acquire: match rises on the edge after the 4th sample is registered.
      hit(0, 0, 0); hit(0, 0, 0); hit(0, 0, 0); hit(0, 0, 0);
      idle(1, 1, 0);
      idle(1, 0, 0);

      // 3 misses, 1 hit, 4 misses: only the final run of 4 releases.
      miss(1, 0, 0); miss(1, 0, 0); miss(1, 0, 0);
      hit(1, 0, 0);
      miss(1, 0, 0); miss(1, 0, 0); miss(1, 0, 0); miss(1, 0, 0);
      idle(0, 0, 1);
      idle(0, 0, 0);
      check("released_state", dbg_state, 0);

      // Hits separated by 5-cycle gaps still lock on the 4th hit.
      for (int h = 0; h < 4; h++) begin
         hit(0, 0, 0);
         for (int k = 0; k < 5; k++)
            idle(h == 3, (h == 3) && (k == 0), 0);
      end
      check("gap_locked_state", dbg_state, 2);

      // CLR with a sample in the same cycle: dropped, no lock_fall.
      cycle(1'b1, 1'b1, 300, 150, 200, model(300, 150, 200), 0, 0, 0);
      idle(0, 0, 0);
      check("clr_state", dbg_state, 0);

      // CLR as the 4th hit would be consumed: lock must not happen.
      hit(0, 0, 0); hit(0, 0, 0); hit(0, 0, 0); hit(0, 0, 0);
      cycle(1'b0, 1'b1, 0, 0, 0, '0, 0, 0, 0);
      idle(0, 0, 0);
      check("clr_inflight_state", dbg_state, 0);

      // Asynchronous reset mid-cycle while locked.
      hit(0, 0, 0); hit(0, 0, 0); hit(0, 0, 0); hit(0, 0, 0);
      idle(1, 1, 0);
      #2;
      RST = 1'b1;
      #1;
      check("arst_match", match, 0);
      check("arst_lock_rise", lock_rise, 0);
      check("arst_lock_fall", lock_fall, 0);
      check("arst_abs_diff", abs_diff, 0);
      check("arst_in_window", in_window, 0);
      check("arst_state", dbg_state, 0);
      @(negedge CLK);
      RST = 1'b0;
      idle(0, 0, 0);
      check("post_arst_state", dbg_state, 0);

      // Sentinel A value: ignored when the feature is built in, ordinary data otherwise.
      for (int s = 0; s < 4; s++)
         cycle(1'b1, 1'b0, 100, 150, 200, model(100, 150, 200), 0, 0, 0);
      idle(!SENT, !SENT, 0);
      idle(!SENT, 0, 0);
      cycle(1'b0, 1'b1, 0, 0, 0, '0, 0, 0, 0);

      check("sb_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
